// File: rtl/wb_mem_arbiter_if.sv
// Wishbone classic master-port bundle used by wb_mem_arbiter.
// Signal names are written from the master's point of view.
`timescale 1ns/1ps
interface wb_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_adr_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW-1:0]   wb_dat_i;
  logic            wb_ack_i;
  logic            wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic master port between instruction
// fetch and the MEM-stage data port, with flush abort and a saturating bus timeout.
`timescale 1ns/1ps
module wb_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_i,
  input  logic [AW-1:0]   i_addr_i,
  output logic [DW-1:0]   i_rdata_o,
  output logic            i_done_o,
  output logic            i_stall_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [AW-1:0]   d_addr_i,
  input  logic [DW/8-1:0] d_sel_i,
  input  logic [DW-1:0]   d_wdata_i,
  output logic [DW-1:0]   d_rdata_o,
  output logic            d_done_o,
  output logic            d_stall_o,
  output logic            err_o,
  input  logic            flush_i,
  wb_mem_arbiter_if.master wb
);

  localparam int SW = DW / 8;
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUS_I, BUS_D} state_e;
  typedef enum logic       {GNT_I, GNT_D}       grant_e;

  state_e          state_q, state_d;
  grant_e          last_q, last_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            i_done_q, i_done_d;
  logic            d_done_q, d_done_d;
  logic            err_q, err_d;
  logic            grant_i, grant_d;
  logic            bus_end, timed_out;

  // NOTE: every _d and helper is defaulted before the case so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    timer_d   = timer_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    wdat_d    = wdat_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    err_d     = 1'b0;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    bus_end   = wb.wb_ack_i | wb.wb_err_i;
    timed_out = (TIMEOUT != 0) && (timer_q == TMO_LAST);

    unique case (state_q)
      IDLE: begin
        // With both requesting, the one that was not served last goes first.
        grant_i = !flush_i && i_req_i && (!d_req_i || last_q == GNT_D);
        grant_d = !flush_i && d_req_i && !grant_i;
        timer_d = '0;
        if (grant_i) begin
          state_d = BUS_I;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          adr_d   = i_addr_i;
          sel_d   = '1;
          wdat_d  = '0;
        end else if (grant_d) begin
          state_d = BUS_D;
          cyc_d   = 1'b1;
          we_d    = d_we_i;
          adr_d   = d_addr_i;
          sel_d   = d_sel_i;
          wdat_d  = d_wdata_i;
        end
      end

      BUS_I, BUS_D: begin
        if (flush_i) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
        end else if (bus_end || timed_out) begin
          // A timeout reports as an error and leaves read data untouched.
          state_d = IDLE;
          cyc_d   = 1'b0;
          err_d   = wb.wb_err_i | ~bus_end;
          if (state_q == BUS_I) begin
            i_done_d = 1'b1;
            last_d   = GNT_I;
            if (bus_end) i_rdata_d = wb.wb_dat_i;
          end else begin
            d_done_d = 1'b1;
            last_d   = GNT_D;
            if (bus_end && !we_q) d_rdata_d = wb.wb_dat_i;
          end
        end else if (timer_q != '1) begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= GNT_D;
      timer_q   <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      sel_q     <= '0;
      wdat_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      wdat_q    <= wdat_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      err_q     <= err_d;
    end
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_dat_o = wdat_q;

  assign i_rdata_o = i_rdata_q;
  assign d_rdata_o = d_rdata_q;
  assign i_done_o  = i_done_q;
  assign d_done_o  = d_done_q;
  assign err_o     = err_q;
  assign i_stall_o = i_req_i & ~i_done_q;
  assign d_stall_o = d_req_i & ~d_done_q;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed vector table, hand-written corner
// sequences, and a randomized run against a transaction-level reference model.
`timescale 1ns/1ps
module tb_wb_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_done, i_stall;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_done, d_stall;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_sel;
  logic        err, flush;

  int checks   = 0;
  int failures = 0;

  wb_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  wb_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_rdata_o(i_rdata), .i_done_o(i_done), .i_stall_o(i_stall),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_sel_i(d_sel), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_done_o(d_done), .d_stall_o(d_stall),
    .err_o(err), .flush_i(flush), .wb(bus)
  );

  always #5 clk = ~clk;

  // resp: 0 = ack, 1 = err, 2 = ack and err together
  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          lat;
    int          resp;
    logic [31:0] sdata;
    bit          exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_dat;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_sel = '0; d_wdata = '0;
    flush = 1'b0;
    bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_dat_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_sel = v.sel; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    @(negedge clk);
    check_b({nm, ".cyc"},   bus.wb_cyc_o, 1'b1);
    check_b({nm, ".stb"},   bus.wb_stb_o, 1'b1);
    check  ({nm, ".adr"},   bus.wb_adr_o, v.addr);
    check_b({nm, ".we"},    bus.wb_we_o, v.exp_we);
    check  ({nm, ".sel"},   32'(bus.wb_sel_o), 32'(v.exp_sel));
    check  ({nm, ".dat"},   bus.wb_dat_o, v.exp_dat);
    check_b({nm, ".stall"}, v.is_d ? d_stall : i_stall, 1'b1);
    repeat (v.lat) @(negedge clk);
    check_b({nm, ".cyc_held"}, bus.wb_cyc_o, 1'b1);
    bus.wb_ack_i = (v.resp != 1);
    bus.wb_err_i = (v.resp != 0);
    bus.wb_dat_i = v.sdata;
    @(negedge clk);
    bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_dat_i = ~v.sdata;
    check_b({nm, ".done"},      v.is_d ? d_done : i_done, 1'b1);
    check_b({nm, ".done_other"}, v.is_d ? i_done : d_done, 1'b0);
    check_b({nm, ".err"},       err, v.exp_err);
    check  ({nm, ".rdata"},     v.is_d ? d_rdata : i_rdata, v.exp_rdata);
    check_b({nm, ".cyc_drop"},  bus.wb_cyc_o, 1'b0);
    check_b({nm, ".stall_rel"}, v.is_d ? d_stall : i_stall, 1'b0);
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check_b({nm, ".done_pulse"}, v.is_d ? d_done : i_done, 1'b0);
  endtask

  // Reference model: one transaction owner at a time, counted in whole bus cycles.
  int          m_owner;   // 0 none, 1 I, 2 D
  int          m_last;    // 1 I, 2 D
  int          m_waited, m_lat;
  bit          m_lat_err;
  logic [31:0] m_adr, m_dat, m_ir, m_dr;
  logic [3:0]  m_sel;
  logic        m_we, m_idone, m_ddone, m_err;

  task automatic model_finish(input bit by_bus, input bit was_err);
    m_err = was_err;
    if (m_owner == 1) begin
      m_idone = 1'b1;
      if (by_bus) m_ir = bus.wb_dat_i;
    end else begin
      m_ddone = 1'b1;
      if (by_bus && !m_we) m_dr = bus.wb_dat_i;
    end
    m_last  = m_owner;
    m_owner = 0;
  endtask

  task automatic rand_cycle();
    @(negedge clk);
    m_idone = 1'b0; m_ddone = 1'b0; m_err = 1'b0;
    if (m_owner == 0) begin
      if (i_req && (!d_req || m_last == 2)) begin
        m_owner = 1; m_adr = i_addr; m_we = 1'b0; m_sel = 4'hF; m_dat = '0;
      end else if (d_req) begin
        m_owner = 2; m_adr = d_addr; m_we = d_we; m_sel = d_sel; m_dat = d_wdata;
      end
      m_waited  = 0;
      m_lat     = $urandom_range(0, 5);
      m_lat_err = ($urandom_range(0, 5) == 0);
    end else if (bus.wb_ack_i || bus.wb_err_i) begin
      model_finish(1'b1, bus.wb_err_i);
    end else begin
      m_waited++;
      if (m_waited == TMO) model_finish(1'b0, 1'b1);
    end

    check_b("rnd.cyc", bus.wb_cyc_o, m_owner != 0);
    check_b("rnd.stb", bus.wb_stb_o, m_owner != 0);
    if (m_owner != 0) begin
      check  ("rnd.adr", bus.wb_adr_o, m_adr);
      check_b("rnd.we",  bus.wb_we_o, m_we);
      check  ("rnd.sel", 32'(bus.wb_sel_o), 32'(m_sel));
      check  ("rnd.dat", bus.wb_dat_o, m_dat);
    end
    check_b("rnd.i_done",  i_done, m_idone);
    check_b("rnd.d_done",  d_done, m_ddone);
    check_b("rnd.err",     err, m_err);
    check  ("rnd.i_rdata", i_rdata, m_ir);
    check  ("rnd.d_rdata", d_rdata, m_dr);
    check_b("rnd.i_stall", i_stall, i_req & ~m_idone);
    check_b("rnd.d_stall", d_stall, d_req & ~m_ddone);

    if (m_idone) i_req = 1'b0;
    if (m_ddone) d_req = 1'b0;
    if (!i_req && $urandom_range(0, 2) == 0) begin
      i_req = 1'b1; i_addr = $urandom;
    end
    if (!d_req && $urandom_range(0, 2) == 0) begin
      d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
      d_sel = 4'($urandom_range(1, 15)); d_wdata = $urandom;
    end
    bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_dat_i = $urandom;
    if (m_owner != 0 && m_waited == m_lat) begin
      if (m_lat_err) bus.wb_err_i = 1'b1;
      else           bus.wb_ack_i = 1'b1;
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    vec_t v;

    vecs[0] = '{0, 0, 32'h0000_0100, 4'h0, 32'h0,         0, 0, 32'h1234_5678, 0, 4'hF, 32'h0,         32'h1234_5678, 0};
    vecs[1] = '{1, 1, 32'h2000_0003, 4'h1, 32'hAAAA_AAAA, 0, 0, 32'h5555_5555, 1, 4'h1, 32'hAAAA_AAAA, 32'h0,         0};
    vecs[2] = '{1, 0, 32'h3000_0010, 4'hF, 32'h1111_1111, 2, 0, 32'hCAFE_F00D, 0, 4'hF, 32'h1111_1111, 32'hCAFE_F00D, 0};
    vecs[3] = '{1, 1, 32'h3000_0014, 4'hC, 32'h1122_3344, 1, 1, 32'h9999_9999, 1, 4'hC, 32'h1122_3344, 32'hCAFE_F00D, 1};
    vecs[4] = '{0, 0, 32'h0000_0104, 4'h0, 32'h0,         3, 1, 32'h0BAD_C0DE, 0, 4'hF, 32'h0,         32'h0BAD_C0DE, 1};
    vecs[5] = '{1, 0, 32'h0000_0040, 4'h3, 32'h0,         1, 2, 32'h8765_4321, 0, 4'h3, 32'h0,         32'h8765_4321, 1};
    vecs[6] = '{0, 0, 32'h0000_0108, 4'h0, 32'h0,         0, 0, 32'hFFFF_FFFF, 0, 4'hF, 32'h0,         32'hFFFF_FFFF, 0};

    do_reset();
    check_b("rst.cyc",     bus.wb_cyc_o, 1'b0);
    check_b("rst.stb",     bus.wb_stb_o, 1'b0);
    check_b("rst.we",      bus.wb_we_o, 1'b0);
    check  ("rst.adr",     bus.wb_adr_o, 32'h0);
    check  ("rst.sel",     32'(bus.wb_sel_o), 32'h0);
    check  ("rst.dat",     bus.wb_dat_o, 32'h0);
    check  ("rst.i_rdata", i_rdata, 32'h0);
    check  ("rst.d_rdata", d_rdata, 32'h0);
    check_b("rst.i_done",  i_done, 1'b0);
    check_b("rst.d_done",  d_done, 1'b0);
    check_b("rst.err",     err, 1'b0);

    for (int k = 0; k < 7; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Both requesters held from reset: I first, then strict alternation.
    do_reset();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_0100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200; d_sel = 4'hF; d_wdata = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_b($sformatf("rr%0d.cyc", k), bus.wb_cyc_o, 1'b1);
      check  ($sformatf("rr%0d.adr", k), bus.wb_adr_o, (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hA000_0000 + 32'(k);
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      check_b($sformatf("rr%0d.i_done", k), i_done, k % 2 == 0);
      check_b($sformatf("rr%0d.d_done", k), d_done, k % 2 == 1);
      check_b($sformatf("rr%0d.cyc_gap", k), bus.wb_cyc_o, 1'b0);
      if (k == 3) begin
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    check("rr.i_rdata", i_rdata, 32'hA000_0002);
    check("rr.d_rdata", d_rdata, 32'hA000_0003);

    // Silent slave: cycle held TMO cycles, then error with read data untouched.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500; d_sel = 4'hF;
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (!bus.wb_cyc_o) break;
      cnt++;
    end
    check  ("tmo.cycles", 32'(cnt), 32'(TMO));
    check_b("tmo.done",   d_done, 1'b1);
    check_b("tmo.err",    err, 1'b1);
    check  ("tmo.rdata",  d_rdata, 32'hA000_0003);
    d_req = 1'b0;
    @(negedge clk);
    check_b("tmo.idle",   bus.wb_cyc_o, 1'b0);
    check_b("tmo.pulse",  d_done, 1'b0);

    // Flush mid-cycle, then a late ack that must be ignored.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_0600;
    @(negedge clk);
    check_b("fl.cyc", bus.wb_cyc_o, 1'b1);
    flush = 1'b1; i_req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check_b("fl.cyc_drop", bus.wb_cyc_o, 1'b0);
    check_b("fl.no_done",  i_done, 1'b0);
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h6666_6666;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    check_b("fl.late_done", i_done, 1'b0);
    check_b("fl.late_cyc",  bus.wb_cyc_o, 1'b0);
    check  ("fl.rdata",     i_rdata, 32'hA000_0002);
    v = '{1, 0, 32'h0000_0700, 4'hF, 32'h0, 0, 0, 32'h0000_0077, 0, 4'hF, 32'h0, 32'h0000_0077, 0};
    run_vec(v, "fl.next_d");

    // Flush on the same edge as ack: the flush wins.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_0800;
    @(negedge clk);
    check_b("fla.cyc", bus.wb_cyc_o, 1'b1);
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h8888_8888; flush = 1'b1; i_req = 1'b0;
    @(negedge clk);
    bus.wb_ack_i = 1'b0; flush = 1'b0;
    check_b("fla.no_done", i_done, 1'b0);
    check_b("fla.cyc",     bus.wb_cyc_o, 1'b0);
    check  ("fla.rdata",   i_rdata, 32'hA000_0002);

    // Randomized traffic against the reference model.
    do_reset();
    m_owner = 0; m_last = 2; m_ir = '0; m_dr = '0; m_waited = 0; m_lat = 0; m_lat_err = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0;
    for (int n = 0; n < 400; n++) rand_cycle();
    idle_inputs();
    repeat (TMO + 2) @(negedge clk);

    // Asynchronous reset in the middle of a bus cycle.
    i_req = 1'b1; i_addr = 32'h0000_0900;
    @(negedge clk);
    check_b("ar.cyc", bus.wb_cyc_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_b("ar.cyc_async", bus.wb_cyc_o, 1'b0);
    check_b("ar.stb_async", bus.wb_stb_o, 1'b0);
    check  ("ar.adr",       bus.wb_adr_o, 32'h0);
    check  ("ar.i_rdata",   i_rdata, 32'h0);
    check_b("ar.i_done",    i_done, 1'b0);
    i_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_b("ar.after_cyc",  bus.wb_cyc_o, 1'b0);
    check_b("ar.after_done", i_done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
